// File: rtl/conv_encoder.sv
// Punctured K=7 convolutional encoder (G1=171, G2=133), rates 1/2, 2/3, 3/4 and 5/6.
// Serial bit in, serial coded bit out through a 2-entry buffer with input backpressure.
module conv_encoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_bits,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_bits,
    output logic       out_valid,
    input  logic [1:0] rate,
    input  logic       reload
);

    logic [5:0] s_r;
    logic [2:0] p_r;
    logic [1:0] rate_r;
    logic [1:0] count_r;
    logic [1:0] fifo_r;
    logic       out_bits_r;
    logic       out_valid_r;

    logic       accept_s;
    logic       pop_s;
    logic       x_s;
    logic       y_s;
    logic       keep_x_s;
    logic       keep_y_s;
    logic [7:0] mask_x_s;
    logic [7:0] mask_y_s;
    logic [2:0] p_last_s;
    logic [2:0] p_next_s;
    logic [1:0] count_next_s;
    logic [1:0] fifo_next_s;

    function automatic logic g1_bit(input logic b, input logic [5:0] s);
        return b ^ s[0] ^ s[1] ^ s[2] ^ s[5];
    endfunction

    function automatic logic g2_bit(input logic b, input logic [5:0] s);
        return b ^ s[1] ^ s[2] ^ s[4] ^ s[5];
    endfunction

    assign in_ready  = (count_r <= 2'd1) && !reload;
    assign out_bits  = out_bits_r;
    assign out_valid = out_valid_r;

    // Mother code, puncture masks (bit n = phase n) and buffer next state
    always_comb begin
        accept_s     = in_valid && in_ready;
        pop_s        = (count_r != 2'd0);
        x_s          = g1_bit(in_bits, s_r);
        y_s          = g2_bit(in_bits, s_r);
        mask_x_s     = 8'h01;
        mask_y_s     = 8'h01;
        p_last_s     = 3'd0;
        fifo_next_s  = fifo_r;
        count_next_s = count_r;
        case (rate_r)
            2'd0: begin
                mask_x_s = 8'h01;
                mask_y_s = 8'h01;
                p_last_s = 3'd0;
            end
            2'd1: begin
                mask_x_s = 8'h01;
                mask_y_s = 8'h03;
                p_last_s = 3'd1;
            end
            2'd2: begin
                mask_x_s = 8'h05;
                mask_y_s = 8'h03;
                p_last_s = 3'd2;
            end
            default: begin
                mask_x_s = 8'h15;
                mask_y_s = 8'h0B;
                p_last_s = 3'd4;
            end
        endcase
        keep_x_s = mask_x_s[p_r];
        keep_y_s = mask_y_s[p_r];
        p_next_s = (p_r == p_last_s) ? 3'd0 : p_r + 3'd1;
        if (accept_s) begin
            // An accept only happens at count<=1, and any held bit pops on the same edge
            fifo_next_s  = keep_x_s ? {y_s, x_s} : {1'b0, y_s};
            count_next_s = {1'b0, keep_x_s} + {1'b0, keep_y_s};
        end else if (pop_s) begin
            fifo_next_s  = {1'b0, fifo_r[1]};
            count_next_s = count_r - 2'd1;
        end else begin
            fifo_next_s  = fifo_r;
            count_next_s = count_r;
        end
    end

    // Trellis state, puncture phase, buffer and registered output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_r         <= 6'd0;
            p_r         <= 3'd0;
            rate_r      <= 2'd0;
            count_r     <= 2'd0;
            fifo_r      <= 2'd0;
            out_bits_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (reload) begin
            s_r         <= 6'd0;
            p_r         <= 3'd0;
            rate_r      <= rate;
            count_r     <= 2'd0;
            fifo_r      <= 2'd0;
            out_bits_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                s_r <= {s_r[4:0], in_bits};
                p_r <= p_next_s;
            end
            count_r     <= count_next_s;
            fifo_r      <= fifo_next_s;
            out_valid_r <= pop_s;
            out_bits_r  <= pop_s ? fifo_r[0] : 1'b0;
        end
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Punctured convolutional encoder for the OFDM transmit chain. It sits directly downstream of the bit randomizer and consumes its serial `out_bits`/`out_valid` stream. It encodes each bit with the 802.16 K=7 mother code (G1=171₈, G2=133₈) and punctures the result to rate 1/2, 2/3, 3/4 or 5/6. The serial coded stream feeds the interleaver, and input backpressure absorbs the rate expansion.

## Interface
- No parameters; the code is fixed at K=7, G1=171₈, G2=133₈.
- `clk` in 1: clock. All state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_bits` in 1: data bit from the randomizer.
- `in_valid` in 1: `in_bits` is valid this cycle.
- `in_ready` out 1: encoder can accept a bit this cycle. Combinational.
- `out_bits` out 1: coded bit. Registered.
- `out_valid` out 1: `out_bits` is valid this cycle. Registered.
- `rate` in 2: code rate select: 0=1/2, 1=2/3, 2=3/4, 3=5/6. Sampled only on `reload`.
- `reload` in 1: start of burst. Clears the trellis state, puncture phase and buffer, and latches `rate`.

## Operation
- **State register** `s[5:0]`:
  - `s[0]` holds the previous input bit and `s[5]` the oldest.
  - On accept of bit `b`: `s <= {s[4:0], b}`.
- **Mother code outputs**:
  - `X = b ^ s[0] ^ s[1] ^ s[2] ^ s[5]` (G1).
  - `Y = b ^ s[1] ^ s[2] ^ s[4] ^ s[5]` (G2).
- **Puncture phase** `p` runs from 0 to period-1.
  - It advances on every accept and wraps to 0 after period-1.
  - Periods are 1, 2, 3, 5 for rate codes 0–3.
- **Keep masks**, listed as phase 0 first:
  - 1/2: X=1, Y=1.
  - 2/3: X=10, Y=11.
  - 3/4: X=101, Y=110.
  - 5/6: X=10101, Y=11010.
- **Kept bits** are pushed into a 2-entry FIFO, X before Y. A phase keeping neither bit never occurs.
- **Output pop**: each cycle with FIFO count > 0, the head moves into `out_bits` and `out_valid` goes to 1. Otherwise `out_valid` goes to 0 and `out_bits` goes to 0.
- **Ready**: `in_ready = (count <= 1) && !reload`.
  - An accept is `in_valid && in_ready`.
  - Pop and push on the same edge are legal. Next count = count − pop + push, and never exceeds 2.
- **Reload**:
  - Clears `s`, `p` and count to 0.
  - Latches `rate`.
  - Drops any buffered bits.
  - `in_valid` in the same cycle is ignored and the bit is lost; `reload` wins.
  - `out_valid` is 0 on the following cycle.
- **Arithmetic**: `p` is 3 bits; the period compare uses the latched rate. The masks are constant.

## Timing
- **Reset values**: `out_bits`=0, `out_valid`=0, `s`=0, `p`=0, count=0, latched rate=0 (1/2). `in_ready` is 1 after reset whenever `reload` is low.
- **Latency**: a bit accepted at edge k gives its first kept coded bit on `out_bits` after edge k+1. The second kept bit appears after edge k+2.
- **Throughput with `in_valid` held high**:
  - Rate 1/2: one accept every 2 cycles, `out_valid` continuously high.
  - Rate 3/4: 3 accepts per 4 output cycles.
  - Rate 5/6: 5 accepts per 6 output cycles.
- **Input timing**: the randomizer updates its outputs on the falling edge, so `in_bits`/`in_valid` are stable at the rising edge. `in_valid` pulses are not held by the source. The upstream wrapper gates randomizer advance with `in_ready` and must not present a bit while `in_ready` is 0.
- **Reset mid-burst**: all outputs drop to their reset values asynchronously. Partially emitted pairs are discarded.

## Test plan
- **Rate 1/2 impulse**: reload with rate=0, then feed 1,0,0,0,0,0,0 → out 11 10 11 11 00 01 11 (XY pairs), `out_valid` high for 14 consecutive cycles.
- **Rate 2/3 impulse**: reload with rate=1, then feed 1,0,0,0 → out 1,1,0,1,1,1 (6 bits). `in_ready` low on every cycle where count=2.
- **Rate 3/4 throughput**: rate=2, `in_valid` held high for 300 inputs of random data → exactly 400 `out_valid` cycles, bit-exact against the reference model. No FIFO overflow is possible, so count never exceeds 2.
- **Rate 5/6 all-ones**: rate=3, 10 ones from zero state → 12 output bits matching the model. `p` wraps at 5 twice.
- **Mid-stream reload**: at rate 1/2, assert reload with `in_valid`=1 while count=2 → next `out_valid`=0, the bit is dropped, the new rate is in effect, and `s` is 0. The following impulse reproduces the first scenario.
- **Async reset mid-output**: assert reset between edges during a burst → `out_valid` and `out_bits` go to 0 immediately. After release, `in_ready`=1 and the first accepted bit encodes from zero state at rate 1/2.
